// File: rtl/collide_scan_if.sv
// Bundle of the collide_scan control, sprite-position and result signals.
// Latency: none, wiring only. Backpressure: none; the scanner ignores start while busy.
// Ports: master = frame/game logic (drives start and positions), slave = scanner (drives results).
interface collide_scan_if #(
    parameter int N_OBJ   = 8,
    parameter int COORD_W = 10
);
    localparam int IDX_W = $clog2(N_OBJ);
    localparam int CNT_W = $clog2(N_OBJ + 1);

    logic                       start;
    logic [COORD_W-1:0]         ref_h;
    logic [COORD_W-1:0]         ref_v;
    logic [N_OBJ*COORD_W-1:0]   obj_h;
    logic [N_OBJ*COORD_W-1:0]   obj_v;
    logic [N_OBJ-1:0]           obj_valid;
    logic                       busy;
    logic                       done;
    logic [N_OBJ-1:0]           hit_mask;
    logic                       hit_any;
    logic [IDX_W-1:0]           first_hit_idx;
    logic [CNT_W-1:0]           hit_count;

    modport master (
        output start, ref_h, ref_v, obj_h, obj_v, obj_valid,
        input  busy, done, hit_mask, hit_any, first_hit_idx, hit_count
    );

    modport slave (
        input  start, ref_h, ref_v, obj_h, obj_v, obj_valid,
        output busy, done, hit_mask, hit_any, first_hit_idx, hit_count
    );
endinterface

// File: rtl/collide_scan.sv
// Sequential player-vs-objects collision scan, one object per clock, results published once per frame.
// Latency: start sampled at edge T -> done pulse visible after edge T+N_OBJ+1 (N_OBJ+2 cycles).
// Backpressure: start is ignored (not queued) while busy; results hold until the next done pulse.
// Ports: clk, rst (sync, active-high); bus (slave): start, ref_h/ref_v, obj_h/obj_v/obj_valid in;
//        busy, done, hit_mask, hit_any, first_hit_idx, hit_count out (all registered).
module collide_scan #(
    parameter int N_OBJ   = 8,
    parameter int COORD_W = 10,
    parameter int TH_H    = 20,
    parameter int TH_V    = 20
) (
    input  logic           clk,
    input  logic           rst,
    collide_scan_if.slave  bus
);
    localparam int IDX_W = $clog2(N_OBJ);
    localparam int CNT_W = $clog2(N_OBJ + 1);

    localparam logic [COORD_W:0]   TH_H_W   = (COORD_W+1)'(TH_H);
    localparam logic [COORD_W:0]   TH_V_W   = (COORD_W+1)'(TH_V);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_OBJ - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_next;

    // Frame snapshot; the scan never looks at the live inputs after start.
    logic [COORD_W-1:0]         r_ref_h;
    logic [COORD_W-1:0]         r_ref_v;
    logic [N_OBJ*COORD_W-1:0]   r_obj_h;
    logic [N_OBJ*COORD_W-1:0]   r_obj_v;
    logic [N_OBJ-1:0]           r_valid;

    // Issue side: object index being evaluated this cycle.
    logic [IDX_W-1:0]           r_idx;
    logic                       r_issue;

    // Compare result is registered before accumulation so the
    // mux -> subtract -> compare path does not also feed the counters.
    logic                       r_stg_vld;
    logic                       r_stg_hit;
    logic                       r_stg_last;
    logic [IDX_W-1:0]           r_stg_idx;

    // Working accumulators for the current scan.
    logic [N_OBJ-1:0]           r_wmask;
    logic [CNT_W-1:0]           r_wcnt;
    logic [IDX_W-1:0]           r_wfirst;
    logic                       r_found;

    // Published results.
    logic [N_OBJ-1:0]           r_hit_mask;
    logic                       r_hit_any;
    logic [IDX_W-1:0]           r_first_hit_idx;
    logic [CNT_W-1:0]           r_hit_count;

    logic [COORD_W-1:0]         w_cur_h;
    logic [COORD_W-1:0]         w_cur_v;
    logic [COORD_W:0]           w_dh;
    logic [COORD_W:0]           w_dv;
    logic                       w_hit;
    logic                       w_idx_last;
    logic                       w_scan_end;

    logic [N_OBJ-1:0]           w_mask_acc;
    logic [CNT_W-1:0]           w_cnt_acc;
    logic [IDX_W-1:0]           w_first_acc;
    logic                       w_found_acc;

    // Distance test for the object at r_idx. Differences are taken one bit
    // wider and always as larger-minus-smaller, so there is no modular wrap.
    always_comb begin
        w_cur_h    = r_obj_h[r_idx*COORD_W +: COORD_W];
        w_cur_v    = r_obj_v[r_idx*COORD_W +: COORD_W];
        w_dh       = (r_ref_h >= w_cur_h) ? ({1'b0, r_ref_h} - {1'b0, w_cur_h})
                                          : ({1'b0, w_cur_h} - {1'b0, r_ref_h});
        w_dv       = (r_ref_v >= w_cur_v) ? ({1'b0, r_ref_v} - {1'b0, w_cur_v})
                                          : ({1'b0, w_cur_v} - {1'b0, r_ref_v});
        w_hit      = r_valid[r_idx] && (w_dh <= TH_H_W) && (w_dv <= TH_V_W);
        w_idx_last = (r_idx == IDX_LAST);
        w_scan_end = r_stg_vld && r_stg_last;
    end

    // Fold the staged result into the working accumulators.
    always_comb begin
        w_mask_acc  = r_wmask;
        w_cnt_acc   = r_wcnt;
        w_first_acc = r_wfirst;
        w_found_acc = r_found;
        if (r_stg_vld && r_stg_hit) begin
            w_mask_acc[r_stg_idx] = 1'b1;
            w_cnt_acc             = r_wcnt + CNT_W'(1);
            if (!r_found) begin
                w_first_acc = r_stg_idx;
                w_found_acc = 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_SCAN;
            S_SCAN:  if (w_scan_end) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_h         <= '0;
            r_ref_v         <= '0;
            r_obj_h         <= '0;
            r_obj_v         <= '0;
            r_valid         <= '0;
            r_idx           <= '0;
            r_issue         <= 1'b0;
            r_stg_vld       <= 1'b0;
            r_stg_hit       <= 1'b0;
            r_stg_last      <= 1'b0;
            r_stg_idx       <= '0;
            r_wmask         <= '0;
            r_wcnt          <= '0;
            r_wfirst        <= '0;
            r_found         <= 1'b0;
            r_hit_mask      <= '0;
            r_hit_any       <= 1'b0;
            r_first_hit_idx <= '0;
            r_hit_count     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ref_h    <= bus.ref_h;
                        r_ref_v    <= bus.ref_v;
                        r_obj_h    <= bus.obj_h;
                        r_obj_v    <= bus.obj_v;
                        r_valid    <= bus.obj_valid;
                        r_idx      <= '0;
                        r_issue    <= 1'b1;
                        r_stg_vld  <= 1'b0;
                        r_stg_hit  <= 1'b0;
                        r_stg_last <= 1'b0;
                        r_stg_idx  <= '0;
                        r_wmask    <= '0;
                        r_wcnt     <= '0;
                        r_wfirst   <= '0;
                        r_found    <= 1'b0;
                    end
                end
                S_SCAN: begin
                    r_stg_vld  <= r_issue;
                    r_stg_hit  <= r_issue && w_hit;
                    r_stg_last <= r_issue && w_idx_last;
                    r_stg_idx  <= r_idx;
                    if (r_issue) begin
                        if (w_idx_last) r_issue <= 1'b0;
                        else            r_idx   <= r_idx + IDX_W'(1);
                    end
                    r_wmask  <= w_mask_acc;
                    r_wcnt   <= w_cnt_acc;
                    r_wfirst <= w_first_acc;
                    r_found  <= w_found_acc;
                    // Results become visible in the DONE cycle, together with done.
                    if (w_scan_end) begin
                        r_hit_mask      <= w_mask_acc;
                        r_hit_any       <= |w_mask_acc;
                        r_first_hit_idx <= w_first_acc;
                        r_hit_count     <= w_cnt_acc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy          = (r_state != S_IDLE);
    assign bus.done          = (r_state == S_DONE);
    assign bus.hit_mask      = r_hit_mask;
    assign bus.hit_any       = r_hit_any;
    assign bus.first_hit_idx = r_first_hit_idx;
    assign bus.hit_count     = r_hit_count;
endmodule

// File: tb/tb_collide_scan.sv
module tb_collide_scan;
    localparam int N  = 8;
    localparam int CW = 10;
    localparam int TH = 20;
    localparam int TV = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    collide_scan_if #(.N_OBJ(N), .COORD_W(CW)) bus();

    collide_scan #(.N_OBJ(N), .COORD_W(CW), .TH_H(TH), .TH_V(TV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int mask;
        int first;
        int cnt;
        int done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    logic prev_done = 1'b0;

    int rh, rv;
    int oh[N];
    int ov[N];
    int vl[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: straight from the rules, on integers.
    function automatic exp_t model();
        exp_t e;
        int dh, dv;
        e.mask = 0; e.first = 0; e.cnt = 0; e.done_cyc = 0;
        for (int k = 0; k < N; k++) begin
            dh = rh - oh[k]; if (dh < 0) dh = -dh;
            dv = rv - ov[k]; if (dv < 0) dv = -dv;
            if (vl[k] != 0 && dh <= TH && dv <= TV) begin
                if (e.cnt == 0) e.first = k;
                e.mask = e.mask | (1 << k);
                e.cnt++;
            end
        end
        return e;
    endfunction

    task automatic drive();
        bus.ref_h = CW'(rh);
        bus.ref_v = CW'(rv);
        for (int k = 0; k < N; k++) begin
            bus.obj_h[k*CW +: CW] = CW'(oh[k]);
            bus.obj_v[k*CW +: CW] = CW'(ov[k]);
            bus.obj_valid[k]      = (vl[k] != 0);
        end
    endtask

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic start_scan(input bit push);
        exp_t e;
        drive();
        bus.start = 1'b1;
        if (push) begin
            e = model();
            e.done_cyc = cyc + N + 2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: timeout, %0d result(s) still pending", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic set_t2();
        rh = 100; rv = 100;
        oh = '{50, 80, 120, 121, 100, 100, 300, 100};
        ov = '{100, 100, 100, 100, 100, 79, 100, 120};
        for (int k = 0; k < N; k++) vl[k] = 1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_mask"},  bus.hit_mask, 0);
        check({tag, "_any"},   bus.hit_any, 0);
        check({tag, "_first"}, bus.first_hit_idx, 0);
        check({tag, "_count"}, bus.hit_count, 0);
    endtask

    // Monitor: pops one expectation for every done pulse the DUT presents.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            check("done_width", prev_done, 0);
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                check("hit_mask",      bus.hit_mask, e.mask);
                check("hit_any",       bus.hit_any, (e.mask != 0));
                check("first_hit_idx", bus.first_hit_idx, e.first);
                check("hit_count",     bus.hit_count, e.cnt);
                check("latency",       cyc, e.done_cyc);
            end
        end
        prev_done <= bus.done;
    end

    initial begin
        bus.start = 1'b0;
        rh = 0; rv = 0;
        for (int k = 0; k < N; k++) begin oh[k] = 0; ov[k] = 0; vl[k] = 0; end
        drive();

        // 1. reset then idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1 check_cleared("t1");

        // 2. mixed hits, exact-threshold and threshold+1 cases
        set_t2();
        start_scan(1);
        check("t2_busy", bus.busy, 1);
        wait_done("t2");
        check("t2_mask",  bus.hit_mask, 8'b1001_0110);
        check("t2_first", bus.first_hit_idx, 1);
        check("t2_count", bus.hit_count, 4);
        @(posedge clk); #1;
        check("t2_busy_after", bus.busy, 0);

        // 3. valid gating
        for (int k = 0; k < N; k++) vl[k] = (k == 1);
        start_scan(1);
        wait_done("t3a");
        check("t3a_mask", bus.hit_mask, 8'b0000_0010);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) vl[k] = 0;
        start_scan(1);
        wait_done("t3b");
        check("t3b_any", bus.hit_any, 0);
        @(posedge clk); #1;

        // 4. no wrap near coordinate extremes
        rh = 0; rv = 0;
        for (int k = 0; k < N; k++) begin oh[k] = 500; ov[k] = 500; vl[k] = 1; end
        oh[0] = 1023; ov[0] = 0;
        oh[1] = 20;   ov[1] = 20;
        oh[2] = 21;   ov[2] = 0;
        start_scan(1);
        wait_done("t4");
        check("t4_mask", bus.hit_mask, 8'b0000_0010);
        @(posedge clk); #1;

        // 5. snapshot: positions change and start pulses mid-scan are ignored
        set_t2();
        start_scan(1);
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin oh[k] = 100; ov[k] = 100; end
        drive(); bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) vl[k] = 0;
        drive(); bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done("t5");
        check("t5_mask", bus.hit_mask, 8'b1001_0110);
        // first IDLE cycle after DONE accepts start
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) begin oh[k] = 100; ov[k] = 100; vl[k] = 1; end
        start_scan(1);
        check("t5_restart_busy", bus.busy, 1);
        wait_done("t5b");
        check("t5b_mask", bus.hit_mask, 8'hFF);
        @(posedge clk); #1;

        // 6. reset mid-scan (results are non-zero beforehand)
        set_t2();
        start_scan(0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_cleared("t6");
        repeat (15) @(posedge clk);
        #1 check("t6_idle_busy", bus.busy, 0);
        start_scan(1);
        wait_done("t6b");
        @(posedge clk); #1;

        // Random frames, objects biased towards the threshold boundary
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0:       rh = $urandom_range(0, 30);
                1:       rh = $urandom_range(993, 1023);
                default: rh = $urandom_range(0, 1023);
            endcase
            rv = $urandom_range(0, 1023);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    oh[k] = rh + $urandom_range(0, 2*TH + 4) - (TH + 2);
                    ov[k] = rv + $urandom_range(0, 2*TV + 4) - (TV + 2);
                    if (oh[k] < 0) oh[k] = 0;
                    if (oh[k] > 1023) oh[k] = 1023;
                    if (ov[k] < 0) ov[k] = 0;
                    if (ov[k] > 1023) ov[k] = 1023;
                end else begin
                    oh[k] = $urandom_range(0, 1023);
                    ov[k] = $urandom_range(0, 1023);
                end
                vl[k] = ($urandom_range(0, 4) != 0);
            end
            start_scan(1);
            wait_done("rand");
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
